// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: funct3 codes, byte enables, FSM states
// and the alignment check shared by the memory-stage unit.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Stores only accept the three signed codes.
  function automatic logic misaligned(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    case (f3)
      F3_B:    return 1'b0;
      F3_H:    return off[0];
      F3_W:    return |off;
      F3_BU:   return st;
      F3_HU:   return st | off[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory valid/ready bus.
// master drives req/we/addr/wdata/be; slave returns ready/rdata/err.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_err;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata, dmem_err
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata, dmem_err
  );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter: lane extract + sign/zero extend of a load word.
// In: rdata, byte offset, funct3. Out: 32-bit result.
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    result = sh;
    case (funct3)
      F3_B:    result = {{24{sh[7]}}, sh[7:0]};
      F3_H:    result = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   result = {24'b0, sh[7:0]};
      F3_HU:   result = {16'b0, sh[15:0]};
      default: result = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store engine on a valid/ready bus.
// Ports: pipeline M inputs, ReadDataW/StallM/MisalignM/FaultM, bus.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataW,
  output logic        StallM,
  output logic        MisalignM,
  output logic        FaultM,
  mem_access_unit_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          fault_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;

  logic          access;
  logic          is_st;
  logic          go;
  logic [1:0]    off;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic [31:0]   ld_data;

  assign off       = ALUResultM[1:0];
  assign access    = MemReadM | MemWriteM;
  assign is_st     = MemWriteM & ~MemReadM;
  assign MisalignM = access & misaligned(is_st, Funct3M, off);
  assign go        = (state == IDLE) & access & ~MisalignM;
  assign StallM    = go | (state == BUSY);
  assign FaultM    = fault_q;

  always_comb begin
    be_n = BE_W;
    wd_n = WriteDataM;
    unique case (1'b1)
      (Funct3M[1:0] == 2'b00): begin
        be_n = BE_B << off;
        wd_n = {4{WriteDataM[7:0]}};
      end
      (Funct3M[1:0] == 2'b01): begin
        be_n = BE_H << off;
        wd_n = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  load_formatter u_fmt (
    .rdata  (bus.dmem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .result (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ReadDataW      <= '0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.dmem_be    <= '0;
      cnt            <= '0;
      fault_q        <= 1'b0;
      f3_q           <= '0;
      off_q          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            state          <= BUSY;
            bus.dmem_req   <= 1'b1;
            bus.dmem_we    <= is_st;
            bus.dmem_addr  <= {ALUResultM[31:2], 2'b00};
            bus.dmem_be    <= be_n;
            bus.dmem_wdata <= wd_n;
            f3_q           <= Funct3M;
            off_q          <= off;
            cnt            <= '0;
          end
        end
        BUSY: begin
          if (bus.dmem_ready) begin
            state        <= DONE;
            bus.dmem_req <= 1'b0;
            if (bus.dmem_err)
              fault_q <= 1'b1;
            else if (!bus.dmem_we)
              ReadDataW <= ld_data;
          end else if (cnt == TLAST) begin
            // Counter lands on TIMEOUT here and stays.
            state        <= DONE;
            bus.dmem_req <= 1'b0;
            fault_q      <= 1'b1;
            cnt          <= cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          fault_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors for mem_access_unit
// with a scripted slave and hand-computed expectations.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataW;
  logic        StallM;
  logic        MisalignM;
  logic        FaultM;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataW  (ReadDataW),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .FaultM     (FaultM),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_n, req_n;
  logic flt;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic clr();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    Funct3M    = 3'b0;
    ALUResultM = '0;
    WriteDataM = '0;
  endtask

  // waits < 0: slave never answers.
  task automatic run(input string tag, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int waits,
                     input logic [31:0] rdat, input logic er);
    int  w;
    bit  done;
    w = 0;
    done = 1'b0;
    stall_n = 0;
    req_n = 0;
    flt = 1'b0;
    @(negedge clk);
    MemReadM   = rd;
    MemWriteM  = wr;
    Funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      bus.dmem_ready = 1'b0;
      bus.dmem_err   = 1'b0;
      if (StallM) stall_n++;
      else if (c > 0) begin
        done = 1'b1;
        flt  = FaultM;
      end
      if (bus.dmem_req) begin
        req_n++;
        if (w == waits) begin
          bus.dmem_ready = 1'b1;
          bus.dmem_rdata = rdat;
          bus.dmem_err   = er;
          cap_addr  = bus.dmem_addr;
          cap_wdata = bus.dmem_wdata;
          cap_be    = bus.dmem_be;
          cap_we    = bus.dmem_we;
        end
        w++;
      end
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    clr();
  endtask

  initial begin
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = '0;
    bus.dmem_err   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.rdw", ReadDataW, 32'h0);
    chk("rst.req", 32'(bus.dmem_req), 32'h0);
    chk("rst.addr", bus.dmem_addr, 32'h0);
    chk("rst.be", 32'(bus.dmem_be), 32'h0);
    chk("rst.wd", bus.dmem_wdata, 32'h0);
    chk("rst.stall", 32'(StallM), 32'h0);
    chk("rst.fault", 32'(FaultM), 32'h0);
    rst_n = 1'b1;

    run("lw", 1, 0, F3_W, 32'h100, 0, 0, 32'hDEADBEEF, 0);
    chk("lw.req", req_n, 1);
    chk("lw.stall", stall_n, 2);
    chk("lw.rdw", ReadDataW, 32'hDEADBEEF);
    chk("lw.addr", cap_addr, 32'h100);
    chk("lw.be", 32'(cap_be), 32'hF);
    chk("lw.we", 32'(cap_we), 32'h0);
    chk("lw.flt", 32'(flt), 32'h0);

    run("lb", 1, 0, F3_B, 32'h103, 0, 3, 32'h80FF0000, 0);
    chk("lb.addr", cap_addr, 32'h100);
    chk("lb.stall", stall_n, 5);
    chk("lb.req", req_n, 4);
    chk("lb.rdw", ReadDataW, 32'hFFFFFF80);

    run("lbu", 1, 0, F3_BU, 32'h103, 0, 3, 32'h80FF0000, 0);
    chk("lbu.rdw", ReadDataW, 32'h00000080);

    run("sh", 0, 1, F3_H, 32'h202, 32'h1234ABCD, 0, 32'hFFFFFFFF, 0);
    chk("sh.we", 32'(cap_we), 32'h1);
    chk("sh.be", 32'(cap_be), 32'hC);
    chk("sh.wd", cap_wdata, 32'hABCDABCD);
    chk("sh.addr", cap_addr, 32'h200);
    chk("sh.rdw", ReadDataW, 32'h00000080);

    run("sb", 0, 1, F3_B, 32'h101, 32'h000000AB, 1, 0, 0);
    chk("sb.be", 32'(cap_be), 32'h2);
    chk("sb.wd", cap_wdata, 32'hABABABAB);
    chk("sb.stall", stall_n, 3);

    run("lh", 1, 0, F3_H, 32'h102, 0, 0, 32'h80011234, 0);
    chk("lh.rdw", ReadDataW, 32'hFFFF8001);
    run("lhu", 1, 0, F3_HU, 32'h102, 0, 0, 32'h80011234, 0);
    chk("lhu.rdw", ReadDataW, 32'h00008001);
    run("lb0", 1, 0, F3_B, 32'h100, 0, 0, 32'h80011234, 0);
    chk("lb0.rdw", ReadDataW, 32'h00000034);

    @(negedge clk);
    MemReadM   = 1'b1;
    Funct3M    = F3_W;
    ALUResultM = 32'h101;
    #1;
    chk("mis.flag", 32'(MisalignM), 32'h1);
    chk("mis.stall", 32'(StallM), 32'h0);
    @(negedge clk);
    chk("mis.req", 32'(bus.dmem_req), 32'h0);
    chk("mis.stall2", 32'(StallM), 32'h0);
    Funct3M    = 3'b011;
    ALUResultM = 32'h100;
    #1;
    chk("mis.f3", 32'(MisalignM), 32'h1);
    MemReadM   = 1'b0;
    MemWriteM  = 1'b1;
    Funct3M    = F3_BU;
    #1;
    chk("mis.sbu", 32'(MisalignM), 32'h1);
    clr();

    run("lb1", 1, 0, F3_BU, 32'h100, 0, 0, 32'h00000080, 0);
    chk("lb1.rdw", ReadDataW, 32'h00000080);

    run("to", 1, 0, F3_W, 32'h300, 0, -1, 32'h0, 0);
    chk("to.req", req_n, 4);
    chk("to.stall", stall_n, 5);
    chk("to.flt", 32'(flt), 32'h1);
    chk("to.rdw", ReadDataW, 32'h00000080);

    run("err", 1, 0, F3_W, 32'h104, 0, 0, 32'h55555555, 1);
    chk("err.flt", 32'(flt), 32'h1);
    chk("err.rdw", ReadDataW, 32'h00000080);

    run("ok", 1, 0, F3_W, 32'h108, 0, 0, 32'h0BADF00D, 0);
    chk("ok.flt", 32'(flt), 32'h0);
    chk("ok.rdw", ReadDataW, 32'h0BADF00D);

    @(negedge clk);
    MemReadM   = 1'b1;
    Funct3M    = F3_W;
    ALUResultM = 32'h400;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ar.req_pre", 32'(bus.dmem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar.req", 32'(bus.dmem_req), 32'h0);
    chk("ar.rdw", ReadDataW, 32'h0);
    chk("ar.addr", bus.dmem_addr, 32'h0);
    clr();
    @(negedge clk);
    rst_n = 1'b1;

    run("post", 1, 0, F3_W, 32'h10, 0, 0, 32'h12345678, 0);
    chk("post.rdw", ReadDataW, 32'h12345678);
    chk("post.stall", stall_n, 2);
    chk("post.flt", 32'(flt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
